// File: rtl/fixed_point_reciprocal_divider_pkg.sv
// Shared definitions for the fixed-point divide unit and its requesters
// (matrix-processor controller and datapath).
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } divState_t;

  localparam int Q_WIDTH = 32;
  localparam int Q_FRAC  = 16;

  localparam logic [31:0] Q_ONE = 32'h0001_0000;
  localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN = 32'h8000_0000;

endpackage

// File: rtl/fixed_point_reciprocal_divider_if.sv
// Start/finished divide handshake between the matrix-processor controller
// (master) and the reciprocal divider (slave).
interface fp_div_if
  import fp_div_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, div_by_zero, overflow
  );

endinterface

// File: rtl/fixed_point_reciprocal_divider.sv
// Multi-cycle signed fixed-point divider used for the perspective
// W-normalisation factor. Radix-2 restoring division on magnitudes, then
// sign application and saturation to the Q(WIDTH-FRAC).FRAC format.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands captured when start is seen
// PREP  | record sign, form magnitudes, load numerator and counter
// ITER  | one restoring step per cycle, ITERS steps, MSB first
// FIXUP | apply sign / saturate / divide-by-zero result, raise done
module fixed_point_reciprocal_divider
  import fp_div_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int FRAC  = Q_FRAC
) (
  input  logic clk,
  input  logic rst_n,
  fp_div_if.slave bus
);

  localparam int ITERS = WIDTH + FRAC;
  localparam int NUM_W = WIDTH + FRAC;
  localparam int CNT_W = $clog2(ITERS);

  // Largest magnitudes representable for a positive / negative result.
  localparam logic [NUM_W-1:0] POS_LIMIT = {{(FRAC+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [NUM_W-1:0] NEG_LIMIT = {{FRAC{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  divState_t        state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] magDiv;
  logic [NUM_W-1:0] num;
  logic [NUM_W-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [WIDTH+1:0] remShift;
  logic [WIDTH:0]   remDiff;
  logic             take;
  logic [CNT_W-1:0] cnt;
  logic             sign;
  logic             zeroFlag;

  logic [WIDTH-1:0] quotientR;
  logic             doneR;
  logic             dbzR;
  logic             ovfR;

  logic [WIDTH-1:0] fixQuot;
  logic             fixDbz;
  logic             fixOvf;

  // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1).
  assign magA = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
  assign magB = opB[WIDTH-1] ? (~opB + 1'b1) : opB;

  // The remainder always stays below |divisor| after a step, so the top
  // bit of the shifted value only matters for the compare.
  assign remShift = {rem, num[NUM_W-1]};
  assign take     = remShift >= {2'b00, magDiv};
  assign remDiff  = remShift[WIDTH:0] - {1'b0, magDiv};

  // Sequencing: IDLE -> PREP -> ITER x ITERS -> FIXUP, with a short-cut to
  // FIXUP on a zero divisor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state <= PREP;
        PREP:    state <= (opB == '0) ? FIXUP : ITER;
        ITER:    if (cnt == '0) state <= FIXUP;
        FIXUP:   state <= IDLE;
      endcase
    end
  end

  // Operand capture and the restoring-division datapath; only meaningful
  // while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (bus.start) begin
          opA <= bus.dividend;
          opB <= bus.divisor;
        end
      end
      PREP: begin
        sign     <= opA[WIDTH-1] ^ opB[WIDTH-1];
        zeroFlag <= (opB == '0);
        magDiv   <= magB;
        num      <= {magA, {FRAC{1'b0}}};
        rem      <= '0;
        quo      <= '0;
        cnt      <= CNT_W'(ITERS - 1);
      end
      ITER: begin
        num <= {num[NUM_W-2:0], 1'b0};
        rem <= take ? remDiff : remShift[WIDTH:0];
        quo <= {quo[NUM_W-2:0], take};
        cnt <= cnt - 1'b1;
      end
      FIXUP: begin
      end
    endcase
  end

  // Final result: divide-by-zero, saturation, or signed truncated quotient.
  always_comb begin
    fixQuot = quo[WIDTH-1:0];
    fixDbz  = 1'b0;
    fixOvf  = 1'b0;
    if (zeroFlag) begin
      fixQuot = opA[WIDTH-1] ? SAT_MIN : SAT_MAX;
      fixDbz  = 1'b1;
    end else if (!sign && (quo > POS_LIMIT)) begin
      fixQuot = SAT_MAX;
      fixOvf  = 1'b1;
    end else if (sign && (quo > NEG_LIMIT)) begin
      fixQuot = SAT_MIN;
      fixOvf  = 1'b1;
    end else if (sign) begin
      fixQuot = ~quo[WIDTH-1:0] + 1'b1;
    end
  end

  // Result registers update only on leaving FIXUP and hold until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      doneR     <= 1'b0;
      quotientR <= '0;
      dbzR      <= 1'b0;
      ovfR      <= 1'b0;
    end else begin
      doneR <= (state == FIXUP);
      if (state == FIXUP) begin
        quotientR <= fixQuot;
        dbzR      <= fixDbz;
        ovfR      <= fixOvf;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = doneR;
  assign bus.quotient    = quotientR;
  assign bus.div_by_zero = dbzR;
  assign bus.overflow    = ovfR;

endmodule

// File: tb/tb_fixed_point_reciprocal_divider.sv
// Self-checking bench for fixed_point_reciprocal_divider: directed corner
// cases, handshake scenarios and random operands against an arithmetic model.
module tb_fixed_point_reciprocal_divider;
  import fp_div_pkg::*;

  localparam int NORMAL_LAT = Q_WIDTH + Q_FRAC + 2;
  localparam int ZERO_LAT   = 2;
  localparam longint MAXV   = 64'sd2147483647;
  localparam longint MINV   = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fp_div_if #(.WIDTH(Q_WIDTH)) bus ();

  fixed_point_reciprocal_divider #(.WIDTH(Q_WIDTH), .FRAC(Q_FRAC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int doneCount = 0;
  int startCycle = 0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;
  always @(negedge clk) if (bus.done === 1'b1) doneCount = doneCount + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued division in Qm.n, truncated toward zero, saturated.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic dz,
                                 output logic ov, output int lat);
    longint na, nb, r;
    na  = longint'($signed(a));
    nb  = longint'($signed(b));
    dz  = 1'b0;
    ov  = 1'b0;
    lat = NORMAL_LAT;
    if (nb == 0) begin
      dz  = 1'b1;
      lat = ZERO_LAT;
      q   = (na >= 0) ? Q_MAX : Q_MIN;
    end else begin
      r = (na * (longint'(1) <<< Q_FRAC)) / nb;
      if (r > MAXV) begin
        q = Q_MAX; ov = 1'b1;
      end else if (r < MINV) begin
        q = Q_MIN; ov = 1'b1;
      end else begin
        q = r[31:0];
      end
    end
  endfunction

  // Called away from a clock edge; start is sampled at the next edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    startCycle = cycleCnt;
  endtask

  task automatic waitDone(output int lat, output bit busyOk);
    lat    = -1;
    busyOk = (bus.busy === 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = cycleCnt - startCycle;
        if (bus.busy !== 1'b0) busyOk = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busyOk = 1'b0;
    end
  endtask

  task automatic checkResult(input string tag, input logic [31:0] q,
                             input logic dz, input logic ov);
    check({tag, " quotient"}, 64'(bus.quotient), 64'(q));
    check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(dz));
    check({tag, " overflow"}, 64'(bus.overflow), 64'(ov));
  endtask

  task automatic runDiv(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic dz, ov;
    int expLat, lat;
    bit busyOk;
    refDiv(a, b, q, dz, ov, expLat);
    launch(a, b);
    waitDone(lat, busyOk);
    check({tag, " latency"}, 64'(lat), 64'(expLat));
    check({tag, " busy"}, 64'(busyOk), 64'(1));
    checkResult(tag, q, dz, ov);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 64'(bus.done), 64'(0));
    check({tag, " held quotient"}, 64'(bus.quotient), 64'(q));
  endtask

  logic [31:0] dirA [8] = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                            32'hFFFF_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
  logic [31:0] dirB [8] = '{32'h0002_0000, 32'hFFFC_0000, 32'h0003_0000, 32'h0000_0000,
                            32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0005_0000};

  initial begin
    logic [31:0] qA, qB, ra, rb;
    logic dzA, ovA, dzB, ovB;
    int latA, latB, lat, d0;
    bit busyOk;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    checkResult("reset", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) runDiv($sformatf("dir%0d", i), dirA[i], dirB[i]);

    // A second start during a divide is ignored.
    refDiv(Q_ONE, 32'h0002_0000, qA, dzA, ovA, latA);
    d0 = doneCount;
    launch(Q_ONE, 32'h0002_0000);
    repeat (9) @(posedge clk);
    #1;
    bus.dividend = 32'h0123_4567;
    bus.divisor  = 32'h0000_0300;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(lat, busyOk);
    check("ignored latency", 64'(lat), 64'(latA));
    checkResult("ignored", qA, dzA, ovA);
    repeat (60) @(posedge clk);
    #1;
    check("ignored done count", 64'(doneCount - d0), 64'(1));
    check("ignored idle", 64'(bus.busy), 64'(0));

    // Back-to-back: new start issued in the done cycle.
    refDiv(32'h0003_0000, 32'h0004_0000, qA, dzA, ovA, latA);
    refDiv(32'hFFFD_0000, 32'h0000_8000, qB, dzB, ovB, latB);
    launch(32'h0003_0000, 32'h0004_0000);
    waitDone(lat, busyOk);
    check("b2b first latency", 64'(lat), 64'(latA));
    checkResult("b2b first", qA, dzA, ovA);
    launch(32'hFFFD_0000, 32'h0000_8000);
    check("b2b accepted busy", 64'(bus.busy), 64'(1));
    check("b2b previous held", 64'(bus.quotient), 64'(qA));
    waitDone(lat, busyOk);
    check("b2b second latency", 64'(lat), 64'(latB));
    check("b2b second busy", 64'(busyOk), 64'(1));
    checkResult("b2b second", qB, dzB, ovB);

    // Reset in the middle of ITER aborts the operation.
    launch(32'h0007_0000, 32'h0002_0000);
    repeat (20) @(posedge clk);
    #1;
    d0    = doneCount;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort done", 64'(bus.done), 64'(0));
    checkResult("abort", 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("abort no done", 64'(doneCount - d0), 64'(0));
    runDiv("after abort", 32'h0001_8000, 32'hFFFF_4000);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      ra = 32'($signed(ra) >>> $urandom_range(0, 31));
      rb = $urandom;
      rb = 32'($signed(rb) >>> $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rb = '0;
      runDiv($sformatf("rand%0d", i), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
